pipelined_execute_unit: RTL and testbench

PIPELINED_EXECUTE_UNIT -- requirements
Module: pipelined_execute_unit

---
 rtl/pipelined_execute_unit.sv | 141 ++++++++++++++
 tb/tb_pipelined_execute_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_execute_unit.sv
// Execute stage: operand resolution, ALU, condition-code register and the EX/MEM pipeline register.
// Define EXEC_FWD_EN to resolve operands from EX/MEM and MEM/WB before the register-file values.
module pipelined_execute_unit #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [2:0]         alu_op,
    input  logic [1:0]         flag_sel,
    input  logic               op2_imm_sel,
    input  logic [DATA_W-1:0]  rs1_data,
    input  logic [DATA_W-1:0]  rs2_data,
    input  logic [DATA_W-1:0]  imm,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    input  logic [3:0]         ctl_in,
    input  logic [RADDR_W-1:0] waddr_in,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0]  imm_out,
    output logic [3:0]         ctl_out,
    output logic [RADDR_W-1:0] waddr_out,
    output logic [2:0]         ccr
);

    localparam int CTL_REG_WE = 3;
    localparam int CTL_MEM_RD = 1;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] rs2_res;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic [DATA_W:0]   wide;
    logic              carry_next;
    logic [2:0]        ccr_next;

`ifdef EXEC_FWD_EN
    logic exmem_fwd_ok;

    // Loads are excluded: their data is not in alu_result, the hazard unit stalls instead.
    assign exmem_fwd_ok = out_valid & ctl_out[CTL_REG_WE] & ~ctl_out[CTL_MEM_RD];

    always_comb begin
        op_a = rs1_data;
        if (exmem_fwd_ok && (waddr_out == rs1_addr)) begin
            op_a = alu_result;
        end else if (wb_we && (wb_addr == rs1_addr)) begin
            op_a = wb_data;
        end

        rs2_res = rs2_data;
        if (exmem_fwd_ok && (waddr_out == rs2_addr)) begin
            rs2_res = alu_result;
        end else if (wb_we && (wb_addr == rs2_addr)) begin
            rs2_res = wb_data;
        end
    end
`else
    logic unused_fwd;

    assign op_a       = rs1_data;
    assign rs2_res    = rs2_data;
    assign unused_fwd = ^{wb_we, wb_addr, wb_data, rs1_addr, rs2_addr};
`endif

    assign op_b = op2_imm_sel ? imm : rs2_res;

    always_comb begin
        wide       = '0;
        result     = '0;
        carry_next = ccr[2];
        case (alu_op)
            3'b000: begin
                wide       = {1'b0, op_a} + {1'b0, op_b};
                result     = wide[DATA_W-1:0];
                carry_next = wide[DATA_W];
            end
            3'b001: begin
                result     = op_a - op_b;
                carry_next = (op_a < op_b);
            end
            3'b010: result = op_a & op_b;
            3'b011: result = op_a | op_b;
            3'b100: result = ~op_a;
            3'b101: begin
                wide       = {1'b0, op_a} + {1'b0, ONE};
                result     = wide[DATA_W-1:0];
                carry_next = wide[DATA_W];
            end
            3'b110: begin
                result     = op_a - ONE;
                carry_next = (op_a == '0);
            end
            default: result = op_b;
        endcase
    end

    // ccr layout is {C, N, Z}; logical ops and pass-through keep C via the carry_next default.
    always_comb begin
        ccr_next = ccr;
        case (flag_sel)
            2'b01:   ccr_next[2] = 1'b1;
            2'b10:   ccr_next[2] = 1'b0;
            2'b11:   ccr_next = {carry_next, result[DATA_W-1], (result == '0)};
            default: ccr_next = ccr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            ctl_out    <= '0;
            waddr_out  <= '0;
            alu_result <= '0;
            mem_wdata  <= '0;
            imm_out    <= '0;
            ccr        <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            out_valid <= 1'b0;
            ctl_out   <= '0;
        end else if (!stall) begin
            out_valid  <= 1'b1;
            ctl_out    <= ctl_in;
            waddr_out  <= waddr_in;
            alu_result <= result;
            mem_wdata  <= rs2_res;
            imm_out    <= imm;
            ccr        <= ccr_next;
        end
    end

endmodule

// File: tb/tb_pipelined_execute_unit.sv
// Self-checking bench for pipelined_execute_unit: directed cases with literal expectations,
// then randomized traffic checked every cycle against an arithmetic reference model.
module tb_pipelined_execute_unit;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int unsigned MASK = (1 << DATA_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic               flush;
    logic               in_valid;
    logic [2:0]         alu_op;
    logic [1:0]         flag_sel;
    logic               op2_imm_sel;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic [DATA_W-1:0]  imm;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [3:0]         ctl_in;
    logic [RADDR_W-1:0] waddr_in;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               out_valid;
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  imm_out;
    logic [3:0]         ctl_out;
    logic [RADDR_W-1:0] waddr_out;
    logic [2:0]         ccr;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: what the EX/MEM register and flags must hold.
    logic               m_valid;
    logic [3:0]         m_ctl;
    logic [RADDR_W-1:0] m_waddr;
    int unsigned        m_res;
    int unsigned        m_wdata;
    int unsigned        m_imm;
    logic               m_c, m_n, m_z;

    pipelined_execute_unit #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_op(alu_op), .flag_sel(flag_sel), .op2_imm_sel(op2_imm_sel),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .ctl_in(ctl_in), .waddr_in(waddr_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .alu_result(alu_result), .mem_wdata(mem_wdata),
        .imm_out(imm_out), .ctl_out(ctl_out), .waddr_out(waddr_out), .ccr(ccr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned resolve(input logic [RADDR_W-1:0] addr, input int unsigned rf);
        int unsigned v = rf;
`ifdef EXEC_FWD_EN
        if (m_valid && m_ctl[3] && !m_ctl[1] && m_waddr == addr) v = m_res;
        else if (wb_we && wb_addr == addr) v = 32'(wb_data);
`endif
        return v;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelStep();
        int unsigned a, r2, b, full;
        logic        c;
        if (!reset) begin
            m_valid = 0; m_ctl = 0; m_waddr = 0; m_res = 0; m_wdata = 0; m_imm = 0;
            {m_c, m_n, m_z} = 3'b000;
        end else if (flush || (!stall && !in_valid)) begin
            m_valid = 0; m_ctl = 0;
        end else if (!stall) begin
            a  = resolve(rs1_addr, 32'(rs1_data));
            r2 = resolve(rs2_addr, 32'(rs2_data));
            b  = op2_imm_sel ? 32'(imm) : r2;
            c  = m_c;
            case (alu_op)
                3'd0: begin full = a + b; c = (full > MASK); end
                3'd1: begin full = a - b; c = (a < b); end
                3'd2: full = a & b;
                3'd3: full = a | b;
                3'd4: full = ~a;
                3'd5: begin full = a + 1; c = (full > MASK); end
                3'd6: begin full = a - 1; c = (a == 0); end
                default: full = b;
            endcase
            full = full & MASK;
            case (flag_sel)
                2'd1: m_c = 1'b1;
                2'd2: m_c = 1'b0;
                2'd3: begin m_c = c; m_n = full[DATA_W-1]; m_z = (full == 0); end
                default: ;
            endcase
            m_valid = 1; m_ctl = ctl_in; m_waddr = waddr_in;
            m_res = full; m_wdata = r2; m_imm = 32'(imm);
        end
    endtask

    task automatic checkOutput();
        checkField("out_valid",  32'(out_valid),  32'(m_valid));
        checkField("ctl_out",    32'(ctl_out),    32'(m_ctl));
        checkField("waddr_out",  32'(waddr_out),  32'(m_waddr));
        checkField("alu_result", 32'(alu_result), m_res);
        checkField("mem_wdata",  32'(mem_wdata),  m_wdata);
        checkField("imm_out",    32'(imm_out),    m_imm);
        checkField("ccr",        32'(ccr),        32'({m_c, m_n, m_z}));
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [1:0] fs,
                                 input logic isel, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] im, input logic [3:0] ctl,
                                 input logic [2:0] wa);
        in_valid = v; alu_op = op; flag_sel = fs; op2_imm_sel = isel;
        rs1_data = a; rs2_data = b; imm = im; ctl_in = ctl; waddr_in = wa;
        step();
    endtask

    function automatic logic [15:0] pickOperand();
        logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
        int idx = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) return corner[idx];
        return 16'($urandom);
    endfunction

    initial begin
        reset = 0; stall = 0; flush = 0; in_valid = 0; alu_op = 0; flag_sel = 0;
        op2_imm_sel = 0; rs1_data = 0; rs2_data = 0; imm = 0; rs1_addr = 0; rs2_addr = 0;
        ctl_in = 0; waddr_in = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        m_valid = 0; m_ctl = 0; m_waddr = 0; m_res = 0; m_wdata = 0; m_imm = 0;
        {m_c, m_n, m_z} = 3'b000;

        step();
        step();
        checkField("reset out_valid", 32'(out_valid), 32'h0);
        checkField("reset ccr",       32'(ccr),       32'h0);

        reset = 1;
        applyStimulus(1, 3'd0, 2'd3, 0, 16'hFFFF, 16'h0001, 16'h0000, 4'h0, 3'd0);
        checkField("add wrap result", 32'(alu_result), 32'h0000);
        checkField("add wrap ccr",    32'(ccr),        32'h5);
        checkField("add out_valid",   32'(out_valid),  32'h1);

        applyStimulus(1, 3'd1, 2'd3, 0, 16'h0003, 16'h0005, 16'h0000, 4'h0, 3'd0);
        checkField("sub result", 32'(alu_result), 32'hFFFE);
        checkField("sub ccr",    32'(ccr),        32'h6);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3'(i), 2'd3, 1'(i), pickOperand(), pickOperand(), pickOperand(),
                          4'hF, 3'(i + 1));
            checkField("stall hold result", 32'(alu_result), 32'hFFFE);
            checkField("stall hold ccr",    32'(ccr),        32'h6);
        end
        flush = 1;
        applyStimulus(1, 3'd0, 2'd3, 0, 16'h1234, 16'h1111, 16'h0, 4'hF, 3'd3);
        checkField("flush out_valid", 32'(out_valid), 32'h0);
        checkField("flush ctl_out",   32'(ctl_out),   32'h0);
        checkField("flush ccr",       32'(ccr),       32'h6);
        stall = 0; flush = 0;

        // Forwarding: r2 written by the previous instruction beats the write-back port.
        rs1_addr = 0; rs2_addr = 5;
        applyStimulus(1, 3'd0, 2'd0, 1, 16'h000F, 16'h0000, 16'h0001, 4'b1000, 3'd2);
        rs1_addr = 2; wb_we = 1; wb_addr = 2; wb_data = 16'h00AA;
        applyStimulus(1, 3'd0, 2'd0, 1, 16'h0000, 16'h1234, 16'h0001, 4'b0000, 3'd4);
`ifdef EXEC_FWD_EN
        checkField("fwd exmem result", 32'(alu_result), 32'h0011);
`else
        checkField("no fwd result", 32'(alu_result), 32'h0001);
`endif
        wb_we = 0; rs1_addr = 0;

        applyStimulus(1, 3'd7, 2'd1, 0, 16'h0000, 16'h0042, 16'h0000, 4'h0, 3'd0);
        applyStimulus(1, 3'd2, 2'd3, 0, 16'h00F0, 16'h0F00, 16'h0000, 4'h0, 3'd0);
        checkField("and zero ccr", 32'(ccr), 32'h5);
        applyStimulus(1, 3'd7, 2'd2, 0, 16'h0000, 16'h8000, 16'h0000, 4'h0, 3'd0);
        checkField("clear C ccr", 32'(ccr), 32'h1);

        stall = 1; reset = 0;
        applyStimulus(1, 3'd0, 2'd3, 0, 16'h0101, 16'h0202, 16'h0303, 4'hA, 3'd6);
        checkField("reset in stall valid", 32'(out_valid), 32'h0);
        stall = 0; reset = 1;
        applyStimulus(1, 3'd5, 2'd3, 0, 16'hFFFF, 16'h0000, 16'h0000, 4'h8, 3'd1);
        checkField("post reset valid",  32'(out_valid),  32'h1);
        checkField("post reset result", 32'(alu_result), 32'h0000);

        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 49) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            rs1_addr = 3'($urandom);
            rs2_addr = 3'($urandom);
            wb_we    = 1'($urandom);
            wb_addr  = 3'($urandom);
            wb_data  = pickOperand();
            applyStimulus(($urandom_range(0, 4) != 0), 3'($urandom), 2'($urandom), 1'($urandom),
                          pickOperand(), pickOperand(), pickOperand(), 4'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
